// File: rtl/reg_dump_reader.sv
// reg_dump_reader: debug client that walks a register-file index range
// through one read port and streams (index, value) pairs over valid/ready.
// CpuHold is raised for the whole walk so the dump is a coherent snapshot.
// Each word takes a READ cycle (address presented, data captured) followed
// by at least one EMIT cycle (word offered until accepted), which caps
// throughput at one word every two cycles.
module reg_dump_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Abort,
  input  logic [ADDR_W-1:0] FirstIdx,
  input  logic [ADDR_W-1:0] LastIdx,
  output logic [ADDR_W-1:0] RegAddr,
  input  logic [DATA_W-1:0] RegData,
  output logic              CpuHold,
  output logic [DATA_W-1:0] DumpData,
  output logic [ADDR_W-1:0] DumpIdx,
  output logic              DumpValid,
  input  logic              DumpReady,
  output logic              Busy,
  output logic              Done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] last;
  logic              handshake;

  // idx only changes on entry to READ, so driving the port from it gives a
  // registered address that holds its last value outside READ.
  assign RegAddr   = idx;
  assign handshake = DumpValid & DumpReady;

  // Walk controller: state, bounds and all registered outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      idx       <= '0;
      last      <= '0;
      DumpData  <= '0;
      DumpIdx   <= '0;
      DumpValid <= 1'b0;
      CpuHold   <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          // Abort outranks a simultaneous Start, so the dump never begins.
          if (Start && !Abort) begin
            idx     <= FirstIdx;
            last    <= LastIdx;
            Busy    <= 1'b1;
            CpuHold <= 1'b1;
            state   <= READ;
          end
        end
        READ: begin
          if (Abort) begin
            DumpValid <= 1'b0;
            Busy      <= 1'b0;
            CpuHold   <= 1'b0;
            state     <= IDLE;
          end else begin
            DumpData  <= RegData;
            DumpIdx   <= idx;
            DumpValid <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          // Abort wins over a handshake in the same cycle: no Done pulse.
          if (Abort) begin
            DumpValid <= 1'b0;
            Busy      <= 1'b0;
            CpuHold   <= 1'b0;
            state     <= IDLE;
          end else if (handshake) begin
            DumpValid <= 1'b0;
            if (idx == last) begin
              Done    <= 1'b1;
              Busy    <= 1'b0;
              CpuHold <= 1'b0;
              state   <= IDLE;
            end else begin
              // Natural wrap at 2**ADDR_W handles FirstIdx > LastIdx.
              idx   <= idx + 1'b1;
              state <= READ;
            end
          end
        end
        default: begin
          DumpValid <= 1'b0;
          Busy      <= 1'b0;
          CpuHold   <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Testbench for reg_dump_reader: a behavioural register file plus a
// word-list reference model of the dump (index sequence and word count from
// modular arithmetic), with randomized contents and backpressure.
module tb_reg_dump_reader;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREG   = 1 << ADDR_W;

  logic              Clk;
  logic              Reset;
  logic              Start;
  logic              Abort;
  logic [ADDR_W-1:0] FirstIdx;
  logic [ADDR_W-1:0] LastIdx;
  logic [ADDR_W-1:0] RegAddr;
  logic [DATA_W-1:0] RegData;
  logic              CpuHold;
  logic [DATA_W-1:0] DumpData;
  logic [ADDR_W-1:0] DumpIdx;
  logic              DumpValid;
  logic              DumpReady;
  logic              Busy;
  logic              Done;

  logic [DATA_W-1:0] regs [NREG];

  int checks = 0;
  int errors = 0;

  reg_dump_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort),
    .FirstIdx(FirstIdx), .LastIdx(LastIdx), .RegAddr(RegAddr),
    .RegData(RegData), .CpuHold(CpuHold), .DumpData(DumpData),
    .DumpIdx(DumpIdx), .DumpValid(DumpValid), .DumpReady(DumpReady),
    .Busy(Busy), .Done(Done)
  );

  // Combinational register-file read port.
  assign RegData = regs[RegAddr];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_regaddr"}, 64'(RegAddr), 64'(0));
    chk({tag, "_data"},    64'(DumpData), 64'(0));
    chk({tag, "_idx"},     64'(DumpIdx), 64'(0));
    chk({tag, "_valid"},   64'(DumpValid), 64'(0));
    chk({tag, "_hold"},    64'(CpuHold), 64'(0));
    chk({tag, "_busy"},    64'(Busy), 64'(0));
    chk({tag, "_done"},    64'(Done), 64'(0));
  endtask

  // mode 0: always ready; 1: random ready; 2: ready low 5 cycles on 2nd word.
  // inject: pulse Start with other bounds mid-dump (must be ignored).
  task automatic run_dump(input int first, input int last, input int mode, input bit inject);
    int n, k, stalls, busy_cyc, word_stall, ei;
    bit exp_valid, fin_hs;
    n = ((last - first) & (NREG - 1)) + 1;
    Start = 1'b1;
    FirstIdx = ADDR_W'(first);
    LastIdx  = ADDR_W'(last);
    tick();
    Start = 1'b0;
    FirstIdx = ADDR_W'($urandom);
    LastIdx  = ADDR_W'($urandom);
    chk("start_regaddr", 64'(RegAddr), 64'(first));
    k = 0; stalls = 0; busy_cyc = 0; word_stall = 0;
    exp_valid = 1'b0; fin_hs = 1'b0;
    for (int cyc = 0; cyc < 2000 && !fin_hs; cyc++) begin
      busy_cyc++;
      case (mode)
        0: DumpReady = 1'b1;
        1: DumpReady = 1'($urandom_range(0, 1));
        default: DumpReady = !(exp_valid && k == 1 && word_stall < 5);
      endcase
      if (mode == 2 && exp_valid && k == 1 && !DumpReady) word_stall++;
      if (inject && cyc == 3) begin
        Start = 1'b1;
        FirstIdx = ADDR_W'(first + 7);
        LastIdx  = ADDR_W'(first + 7);
      end else begin
        Start = 1'b0;
      end
      chk("busy", 64'(Busy), 64'(1));
      chk("cpuhold", 64'(CpuHold), 64'(1));
      chk("done_early", 64'(Done), 64'(0));
      chk("valid", 64'(DumpValid), 64'(exp_valid));
      if (exp_valid) begin
        ei = (first + k) % NREG;
        chk("word_idx", 64'(DumpIdx), 64'(ei));
        chk("word_data", 64'(DumpData), 64'(regs[ei]));
        if (DumpReady) begin
          k++;
          exp_valid = 1'b0;
          if (k == n) fin_hs = 1'b1;
        end else begin
          stalls++;
        end
      end else begin
        exp_valid = 1'b1;
      end
      tick();
    end
    Start = 1'b0;
    chk("word_count", 64'(k), 64'(n));
    if (fin_hs) begin
      chk("done_pulse", 64'(Done), 64'(1));
      chk("busy_off", 64'(Busy), 64'(0));
      chk("hold_off", 64'(CpuHold), 64'(0));
      chk("valid_off", 64'(DumpValid), 64'(0));
      chk("busy_cycles", 64'(busy_cyc), 64'(2 * n + stalls));
      tick();
      chk("done_single", 64'(Done), 64'(0));
      chk("idle_busy", 64'(Busy), 64'(0));
    end
    DumpReady = 1'b0;
  endtask

  initial begin
    int f, l;
    Reset = 1'b0; Start = 1'b0; Abort = 1'b0;
    FirstIdx = '0; LastIdx = '0; DumpReady = 1'b0;
    regs[0] = '0;
    for (int i = 1; i < NREG; i++) regs[i] = 32'h1000_0000 + DATA_W'(i);

    // Reset state
    tick(); tick();
    chk_all_zero("reset");
    Reset = 1'b1;
    tick();
    chk_all_zero("post_reset");

    // Directed dumps from the test plan
    run_dump(3, 5, 0, 1'b0);
    run_dump(0, 31, 0, 1'b0);
    run_dump(30, 1, 0, 1'b0);
    run_dump(7, 7, 0, 1'b0);
    run_dump(3, 5, 2, 1'b0);

    // Start while busy is ignored
    run_dump(10, 20, 1, 1'b1);

    // Abort on word 4 with a same-cycle handshake
    Start = 1'b1; FirstIdx = 5'd3; LastIdx = 5'd5;
    tick();
    Start = 1'b0; DumpReady = 1'b1;
    begin
      bit found;
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
        if (DumpValid && DumpIdx == 5'd4) found = 1'b1;
        else tick();
      end
      chk("abort_reach_word4", 64'(found), 64'(1));
    end
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk("abort_valid", 64'(DumpValid), 64'(0));
    chk("abort_busy", 64'(Busy), 64'(0));
    chk("abort_hold", 64'(CpuHold), 64'(0));
    chk("abort_done", 64'(Done), 64'(0));
    tick();
    chk("abort_done_late", 64'(Done), 64'(0));
    chk("abort_idle", 64'(Busy), 64'(0));
    DumpReady = 1'b0;
    run_dump(0, 31, 1, 1'b0);

    // Abort alone in IDLE, then Start+Abort together in IDLE
    Abort = 1'b1;
    tick();
    chk("idle_abort_busy", 64'(Busy), 64'(0));
    Start = 1'b1;
    tick();
    Start = 1'b0; Abort = 1'b0;
    chk("start_abort_busy", 64'(Busy), 64'(0));
    chk("start_abort_hold", 64'(CpuHold), 64'(0));
    tick();
    chk("start_abort_valid", 64'(DumpValid), 64'(0));
    chk("start_abort_busy2", 64'(Busy), 64'(0));

    // Randomized contents, bounds and backpressure
    for (int t = 0; t < 6; t++) begin
      for (int i = 1; i < NREG; i++) regs[i] = $urandom;
      f = int'($urandom_range(0, NREG - 1));
      l = int'($urandom_range(0, NREG - 1));
      run_dump(f, l, 1, 1'b0);
    end

    // Asynchronous reset mid-dump
    Start = 1'b1; FirstIdx = 5'd0; LastIdx = 5'd31; DumpReady = 1'b1;
    tick();
    Start = 1'b0;
    tick(); tick(); tick();
    chk("pre_reset_busy", 64'(Busy), 64'(1));
    #2;
    Reset = 1'b0;
    #1;
    chk_all_zero("async_reset");
    tick();
    Reset = 1'b1;
    DumpReady = 1'b0;
    tick();
    chk("reset_release_busy", 64'(Busy), 64'(0));
    chk("reset_release_done", 64'(Done), 64'(0));
    run_dump(28, 2, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
Debug read-side client of the CPU register file. On command, it walks a register index range through one register-file read port and streams each (index, value) pair out over a valid/ready interface. It asserts CpuHold while active so register writes are frozen and the dump is a coherent snapshot. It sits beside the datapath and drives a read address into the register file in place of the decode stage while busy.

Parameters:
ADDR_W, 5, register index width (register count = 2**ADDR_W)
DATA_W, 32, register data width

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  asynchronous, active-low reset
Start  input  1  one-cycle dump request; sampled only in IDLE
Abort  input  1  cancel an in-progress dump
FirstIdx  input  ADDR_W  first register index; sampled with Start
LastIdx  input  ADDR_W  last register index; sampled with Start
RegAddr  output  ADDR_W  read address to the register-file port
RegData  input  DATA_W  combinational read data for RegAddr
CpuHold  output  1  freeze request to the CPU (no RegWr while high)
DumpData  output  DATA_W  register value being offered
DumpIdx  output  ADDR_W  index of DumpData
DumpValid  output  1  DumpData/DumpIdx valid
DumpReady  input  1  consumer accepts the current word
Busy  output  1  dump in progress
Done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset low (async): state IDLE; RegAddr=0, DumpData=0, DumpIdx=0, DumpValid=0, CpuHold=0, Busy=0, Done=0; internal idx, last and count cleared.
- States: IDLE, READ, EMIT.
- IDLE: Busy=0, CpuHold=0, DumpValid=0. Start=1 -> latch idx=FirstIdx, last=LastIdx; go to READ. Busy and CpuHold go high on the next edge.
- READ (one cycle): RegAddr=idx. At the edge: DumpData<=RegData, DumpIdx<=idx, DumpValid<=1; go to EMIT.
- Register 0 is read through the port like any other index and must return 0.
- EMIT: hold DumpData, DumpIdx, DumpValid stable until DumpReady=1.
- On handshake (DumpValid & DumpReady):
  - If idx==last: DumpValid<=0, Done<=1 for one cycle, Busy<=0, CpuHold<=0; go to IDLE.
  - Else: idx<=idx+1 (mod 2**ADDR_W); DumpValid<=0; go to READ.
- Throughput: at most one word per 2 cycles.
- Wrap-around: when FirstIdx>LastIdx, the walk runs FirstIdx..31, then 0..LastIdx.
- Word count = ((LastIdx-FirstIdx) mod 2**ADDR_W)+1. FirstIdx==LastIdx produces exactly one word.
- Full range: FirstIdx=0, LastIdx=31 produces 32 words.
- Start while Busy is ignored; latched bounds do not change.
- Abort=1 in READ or EMIT: next edge -> IDLE, DumpValid=0, Busy=0, CpuHold=0, no Done pulse. Abort has priority over a same-cycle handshake.
- Abort in IDLE has no effect. Start and Abort together in IDLE: Abort wins, the dump does not start.
- CpuHold is registered and high exactly while Busy is high. The CPU is required to suppress RegWr while CpuHold=1; this block does not check it.
- RegAddr outside READ holds its last value; the register-file read is harmless.
- Reset low mid-dump: immediate return to the reset values, no Done pulse.

Test Plan:
- Preload r1..r31 = 0x1000_0000+i; Start FirstIdx=3, LastIdx=5, DumpReady=1 -> words (3,0x10000003), (4,0x10000004), (5,0x10000005) on alternating cycles; Done pulses once, 2 cycles after the last READ; Busy/CpuHold high for 6 cycles.
- Start FirstIdx=0, LastIdx=31, DumpReady=1 -> 32 words, the first being (0,0x00000000); DumpIdx strictly increments 0..31; Done once.
- Start FirstIdx=30, LastIdx=1 -> idx sequence 30, 31, 0, 1 (4 words), then Done.
- Backpressure: DumpReady low for 5 cycles on word 2 of a 3..5 dump -> DumpData and DumpIdx stable and DumpValid held high throughout; no word lost or duplicated.
- Abort while EMIT of word 4 in a 3..5 dump, with DumpReady=1 the same cycle -> next cycle IDLE, DumpValid=0, CpuHold=0, no Done; a second Start then runs a full dump.
- Reset driven low mid-dump, asynchronously between edges -> all outputs 0 immediately; Start during the dump ignored; Start+Abort together in IDLE -> no dump starts.
